// File: rtl/bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_pkg
// Purpose  : Shared types and constants for the BCD display unit: conversion
//            FSM states, active-high seven-segment patterns (bit 6 = a ..
//            bit 0 = g), digit/shift counts and a polarity helper.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NDIGITS = 3;
  localparam int NSHIFT  = 8;

  // Active-high patterns, a..g from MSB to LSB.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  // Convert an active-high pattern to the pin level the board expects.
  function automatic logic [6:0] seg_drive(input logic [6:0] seg, input logic active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_unit_seg7.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit_decode
// Purpose  : Combinational BCD digit to active-high seven-segment decode.
//            Codes 10-15 never come out of the converter and decode blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_digit_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup, anything outside 0-9 shows nothing.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_display_unit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_unit
// Purpose  : Captures a two's-complement byte on LOAD, converts its magnitude
//            to three BCD digits with a shift-add-3 engine (8 shift cycles)
//            and registers sign, BCD and segment patterns when done. Displays
//            hold the previous value until the next conversion finishes.
// Options  : define BCD_DISPLAY_UNIT_BLANK_LEADING_EN to blank leading zero
//            digits (ones digit is always shown).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_unit
  import bcd_display_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   LOAD,
  input  logic [WIDTH-1:0]       BINARY,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   NEG,
  output logic [4*NDIGITS-1:0]   BCD,
  output logic [0:6]             HEXONES,
  output logic [0:6]             HEXTENS,
  output logic [0:6]             HEXHUNDREDS,
  output logic [0:6]             HEXSIGN
);

  localparam logic [2:0] CNT_LAST = 3'(NSHIFT - 1);

`ifdef BCD_DISPLAY_UNIT_BLANK_LEADING_EN
  localparam logic [6:0] LEAD_ZERO = SEG_BLANK;
`else
  localparam logic [6:0] LEAD_ZERO = SEG_0;
`endif

  state_t                       state;
  state_t                       state_next;
  logic [2:0]                   cnt;
  logic                         neg_pend;
  logic [4*NDIGITS-1:0]         bcd_sr;
  logic [WIDTH-1:0]             mag_sr;
  logic [WIDTH-1:0]             mag_in;
  logic [4*NDIGITS-1:0]         adj;
  logic [4*NDIGITS+WIDTH-1:0]   shifted;
  logic [6:0]                   dec_seg [NDIGITS];
  logic [6:0]                   seg_ones;
  logic [6:0]                   seg_tens;
  logic [6:0]                   seg_hund;

  // Magnitude of the input; 0x80 wraps to 0x80, read unsigned as 128.
  assign mag_in = BINARY[WIDTH-1] ? (~BINARY + WIDTH'(1)) : BINARY;

  // Add 3 to every nibble of 5 or more so the following shift carries into the next digit.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? (bcd_sr[4*i +: 4] + 4'd3)
                                                      : bcd_sr[4*i +: 4];
  end

  assign shifted = {adj, mag_sr} << 1;

  // One decoder per digit: index 0 = ones, 1 = tens, 2 = hundreds.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_dec
    seg7_digit_decode u_dec (
      .digit (bcd_sr[4*i +: 4]),
      .seg   (dec_seg[i])
    );
  end

  // Choose what each digit shows, blanking leading zeros when enabled.
  always_comb begin
    seg_ones = dec_seg[0];
    seg_tens = dec_seg[1];
    seg_hund = dec_seg[2];
`ifdef BCD_DISPLAY_UNIT_BLANK_LEADING_EN
    if (bcd_sr[11:8] == 4'd0) begin
      seg_hund = SEG_BLANK;
      if (bcd_sr[7:4] == 4'd0) seg_tens = SEG_BLANK;
    end
`endif
  end

  // State register.
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and busy decode.
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    case (state)
      IDLE:    if (LOAD) state_next = SHIFT;
      SHIFT: begin
        BUSY = 1'b1;
        if (cnt == CNT_LAST) state_next = FINISH;
      end
      FINISH: begin
        BUSY       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: capture on accepted load, shift once per SHIFT cycle.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt      <= '0;
      neg_pend <= 1'b0;
      bcd_sr   <= '0;
      mag_sr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            neg_pend <= BINARY[WIDTH-1];
            mag_sr   <= mag_in;
            bcd_sr   <= '0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          {bcd_sr, mag_sr} <= shifted;
          cnt              <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: update only at FINISH so the displays never flicker.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      DONE        <= 1'b0;
      NEG         <= 1'b0;
      BCD         <= '0;
      HEXONES     <= seg_drive(SEG_0, SEG_ACTIVE_LOW);
      HEXTENS     <= seg_drive(LEAD_ZERO, SEG_ACTIVE_LOW);
      HEXHUNDREDS <= seg_drive(LEAD_ZERO, SEG_ACTIVE_LOW);
      HEXSIGN     <= seg_drive(SEG_BLANK, SEG_ACTIVE_LOW);
    end else begin
      DONE <= (state == FINISH);
      if (state == FINISH) begin
        NEG         <= neg_pend;
        BCD         <= bcd_sr;
        HEXONES     <= seg_drive(seg_ones, SEG_ACTIVE_LOW);
        HEXTENS     <= seg_drive(seg_tens, SEG_ACTIVE_LOW);
        HEXHUNDREDS <= seg_drive(seg_hund, SEG_ACTIVE_LOW);
        HEXSIGN     <= seg_drive(neg_pend ? SEG_MINUS : SEG_BLANK, SEG_ACTIVE_LOW);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_unit
// Purpose  : Scoreboard bench for bcd_display_unit. The driver decides from
//            its own timing model whether a load is accepted and queues the
//            decimal result; the monitor checks DONE, BUSY and all display
//            outputs every cycle against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_unit;

  localparam bit AL = 1'b1;

  typedef struct {
    int         done_edge;
    logic [11:0] bcd;
    logic        neg;
    logic [6:0]  ho;
    logic [6:0]  ht;
    logic [6:0]  hh;
    logic [6:0]  hs;
  } exp_t;

  logic        CLOCK;
  logic        RESET;
  logic        LOAD;
  logic [7:0]  BINARY;
  logic        busy;
  logic        done;
  logic        neg;
  logic [11:0] bcd;
  logic [6:0]  hex_ones;
  logic [6:0]  hex_tens;
  logic [6:0]  hex_hund;
  logic [6:0]  hex_sign;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   edge_cnt = 0;
  bit   rst_at_edge = 1'b1;
  int   last_k = -1000;
  exp_t q[$];
  exp_t cur;

  bcd_display_unit #(.WIDTH(8), .SEG_ACTIVE_LOW(AL)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .LOAD        (LOAD),
    .BINARY      (BINARY),
    .BUSY        (busy),
    .DONE        (done),
    .NEG         (neg),
    .BCD         (bcd),
    .HEXONES     (hex_ones),
    .HEXTENS     (hex_tens),
    .HEXHUNDREDS (hex_hund),
    .HEXSIGN     (hex_sign)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    edge_cnt    = edge_cnt + 1;
    rst_at_edge = RESET;
  end

  function automatic logic [6:0] pins(input logic [6:0] p);
    return AL ? ~p : p;
  endfunction

  // Active-high a..g patterns for decimal digits.
  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input int value, input int when);
    exp_t e;
    int   mag, h, t, o;
    bit   blank_lead;
`ifdef BCD_DISPLAY_UNIT_BLANK_LEADING_EN
    blank_lead = 1'b1;
`else
    blank_lead = 1'b0;
`endif
    mag = (value < 0) ? -value : value;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    e.done_edge = when;
    e.neg = (value < 0);
    e.bcd = 12'(h * 256 + t * 16 + o);
    e.ho  = pins(digit_seg(o));
    e.ht  = pins((blank_lead && h == 0 && t == 0) ? 7'b0000000 : digit_seg(t));
    e.hh  = pins((blank_lead && h == 0) ? 7'b0000000 : digit_seg(h));
    e.hs  = pins(e.neg ? 7'b0000001 : 7'b0000000);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: retire queued results at their DONE edge and check every output.
  always @(negedge CLOCK) begin : mon
    bit done_exp;
    bit busy_exp;
    done_exp = 1'b0;
    busy_exp = 1'b0;
    if (rst_at_edge) begin
      q.delete();
      cur = model(0, 0);
    end else if (q.size() > 0) begin
      if (q[0].done_edge == edge_cnt) begin
        cur = q.pop_front();
        done_exp = 1'b1;
      end else if (edge_cnt >= q[0].done_edge - 9 && edge_cnt < q[0].done_edge) begin
        busy_exp = 1'b1;
      end
    end
    check("DONE", 32'(done), 32'(done_exp));
    check("BUSY", 32'(busy), 32'(busy_exp));
    check("BCD", 32'(bcd), 32'(cur.bcd));
    check("NEG", 32'(neg), 32'(cur.neg));
    check("HEXONES", 32'(hex_ones), 32'(cur.ho));
    check("HEXTENS", 32'(hex_tens), 32'(cur.ht));
    check("HEXHUNDREDS", 32'(hex_hund), 32'(cur.hh));
    check("HEXSIGN", 32'(hex_sign), 32'(cur.hs));
  end

  // Drive one cycle; the load is accepted only if the converter will be idle.
  task automatic cyc(input bit rst, input bit ld, input logic [7:0] b);
    int v;
    @(negedge CLOCK);
    #1;
    RESET  = rst;
    LOAD   = ld;
    BINARY = b;
    if (rst) begin
      last_k = -1000;
    end else if (ld && (edge_cnt + 1 >= last_k + 10)) begin
      last_k = edge_cnt + 1;
      v = $signed(b);
      q.push_back(model(v, last_k + 9));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic convert(input logic [7:0] b);
    cyc(1'b0, 1'b1, b);
    idle(11);
  endtask

  initial begin
    RESET  = 1'b1;
    LOAD   = 1'b0;
    BINARY = 8'h00;
    cur    = model(0, 0);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    idle(2);
    convert(8'h2A);
    convert(8'h80);
    convert(8'hFF);
    convert(8'h7F);
    convert(8'h00);
    // Second load while busy must be dropped.
    cyc(1'b0, 1'b1, 8'h10);
    idle(2);
    cyc(1'b0, 1'b1, 8'h63);
    idle(12);
    // Load in the DONE cycle is accepted.
    cyc(1'b0, 1'b1, 8'hFB);
    idle(9);
    cyc(1'b0, 1'b1, 8'h63);
    idle(12);
    // Reset mid-conversion aborts with no DONE.
    cyc(1'b0, 1'b1, 8'h55);
    idle(3);
    cyc(1'b1, 1'b1, 8'h12);
    idle(20);
    // Reset together with load: reset wins.
    cyc(1'b1, 1'b1, 8'h44);
    idle(12);
    // Random traffic, including back-to-back and occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    idle(15);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
